scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_pkg.sv | 6 +
 rtl/scan_decoder_onehot_dec.sv | 10 +
 rtl/scan_decoder.sv | 78 +++++++
 tb/tb_scan_decoder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding and request mode constants for scan_decoder
package scan_decoder_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational index to one-hot decoder
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]    idx,
    output logic [2**SEL_W-1:0] onehot
);
    localparam int N = 2**SEL_W;
    assign onehot = N'(1) << idx;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: one-hot hold/scan sequencer; SCAN_DECODER_OVERRUN_EN adds a sticky overrun err output
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2**SEL_W-1:0] out,
    output logic                busy,
    output logic                done
`ifdef SCAN_DECODER_OVERRUN_EN
    ,output logic               err
`endif
);
    localparam int N = 2**SEL_W;
    state_t state;
    logic [SEL_W-1:0] idx, start, nxt, inc;
    logic [DWELL_W-1:0] cnt, dwell_r;
    logic [N-1:0] dec;
    logic fin;
    assign in_ready = (state == IDLE) & en;
    assign busy = state != IDLE;
    assign inc = SEL_W'(idx + 1'b1);
    // a scan ends when the next index would land back on the start index
    always_comb begin
        nxt = (state == IDLE) ? sel : (state == SCAN && cnt == '0) ? inc : idx;
        fin = (cnt == '0) & ((state == HOLD) | (state == SCAN & inc == start));
    end
    onehot_dec #(.SEL_W(SEL_W)) u_dec (.idx(nxt), .onehot(dec));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            start <= '0;
            cnt <= '0;
            dwell_r <= '0;
            out <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!en) begin
                out <= '0;
            end else if (state == IDLE) begin
                out <= '0;
                if (in_valid) begin
                    state <= (mode == MODE_SCAN) ? SCAN : HOLD;
                    idx <= sel;
                    start <= sel;
                    cnt <= dwell;
                    dwell_r <= dwell;
                    out <= dec;
                end
            end else if (fin) begin
                state <= IDLE;
                out <= '0;
                done <= 1'b1;
            end else begin
                idx <= nxt;
                cnt <= (cnt == '0) ? dwell_r : cnt - 1'b1;
                out <= dec;
            end
        end
    end
`ifdef SCAN_DECODER_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (in_valid & ~in_ready) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed and random checks of scan_decoder against a queue-based sequence model
module tb_scan_decoder;
    logic clk, rst_n, en, mode, in_valid, in_ready, busy, done;
    logic [2:0] sel;
    logic [3:0] dwell;
    logic [7:0] out;
    int n_cmp, n_err;
    logic [7:0] q[$];
    logic active;
`ifdef SCAN_DECODER_OVERRUN_EN
    logic err, err_m;
`endif
    scan_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .busy(busy), .done(done)
`ifdef SCAN_DECODER_OVERRUN_EN
        , .err(err)
`endif
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // a request expands to the full list of out values it should produce, one per enabled cycle
    task automatic load(input logic m, input logic [2:0] s, input logic [3:0] d);
        q.delete();
        for (int k = 0; k < (m ? 8 : 1); k++)
            for (int r = 0; r <= int'(d); r++)
                q.push_back(8'(1 << ((int'(s) + k) % 8)));
    endtask
    task automatic check_all(input logic [7:0] eo, input logic eb, input logic ed, input logic er);
        chk("out", 32'(out), 32'(eo));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("in_ready", 32'(in_ready), 32'(er));
`ifdef SCAN_DECODER_OVERRUN_EN
        chk("err", 32'(err), 32'(err_m));
`endif
    endtask
    task automatic step(input logic v, input logic m, input logic [2:0] s, input logic [3:0] d, input logic e);
        logic [7:0] eo;
        logic eb, ed;
        in_valid = v; mode = m; sel = s; dwell = d; en = e;
`ifdef SCAN_DECODER_OVERRUN_EN
        if (v && (active || !e)) err_m = 1'b1;
`endif
        eo = 8'h00; eb = active; ed = 1'b0;
        if (e && !active && v) begin
            load(m, s, d);
            active = 1'b1;
            eo = q.pop_front();
            eb = 1'b1;
        end else if (e && active && q.size() != 0) begin
            eo = q.pop_front();
        end else if (e && active) begin
            eb = 1'b0;
            ed = 1'b1;
            active = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(eo, eb, ed, !active && e);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        active = 1'b0;
        q.delete();
`ifdef SCAN_DECODER_OVERRUN_EN
        err_m = 1'b0;
`endif
        #1;
        check_all(8'h00, 1'b0, 1'b0, en);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    endtask
    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = '0; dwell = '0; in_valid = 1'b0;
        active = 1'b0;
`ifdef SCAN_DECODER_OVERRUN_EN
        err_m = 1'b0;
`endif
        do_reset();
        // hold sel=5 dwell=2
        step(1'b1, 1'b0, 3'd5, 4'd2, 1'b1);
        idle(4);
        // scan from 6 with single-cycle dwell
        step(1'b1, 1'b1, 3'd6, 4'd0, 1'b1);
        idle(9);
        // pause mid-hold
        step(1'b1, 1'b0, 3'd1, 4'd3, 1'b1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        idle(5);
        // reset mid-scan, then a normal request
        step(1'b1, 1'b1, 3'd2, 4'd1, 1'b1);
        idle(3);
        do_reset();
        step(1'b1, 1'b0, 3'd3, 4'd1, 1'b1);
        idle(3);
        // in_valid held during hold with changing fields
        step(1'b1, 1'b0, 3'd4, 4'd3, 1'b1);
        step(1'b1, 1'b1, 3'd7, 4'd0, 1'b1);
        step(1'b1, 1'b1, 3'd2, 4'd9, 1'b1);
        idle(3);
        // back-to-back accept right after done
        step(1'b1, 1'b0, 3'd2, 4'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        idle(2);
        // longest dwell
        step(1'b1, 1'b0, 3'd7, 4'd15, 1'b1);
        idle(17);
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(2) == 0, 1'($urandom_range(1)), 3'($urandom_range(7)),
                 ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3)), $urandom_range(7) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
